// File: rtl/ysyx_22041207_pkg.sv
// rtl/ysyx_22041207_pkg.sv - shared types and default widths for the memory arbiter
package ysyx_22041207_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCKED = 2'd1,
        ARB_BUSY   = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam int ARB_ADDR_W      = 64;
    localparam int ARB_DATA_W      = 64;
    localparam int ARB_MAX_IF_WAIT = 4;
    localparam int ARB_CNT_W       = 3;

endpackage

// File: rtl/ysyx_22041207_arb_pick.sv
// rtl/ysyx_22041207_arb_pick.sv - combinational LS-over-IF selector with starvation override
module ysyx_22041207_arb_pick
    import ysyx_22041207_pkg::*;
#(
    parameter int MAX_IF_WAIT = ARB_MAX_IF_WAIT,
    parameter int CNT_W       = ARB_CNT_W
)
(
    input  logic             i_if_valid,
    input  logic             i_ls_valid,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_valid,
    output logic             o_owner
);

    logic w_if_forced;

    // IF only wins against LS once it has waited out MAX_IF_WAIT LS grants
    assign w_if_forced = i_if_valid && (i_starve_cnt == CNT_W'(MAX_IF_WAIT));
    assign o_valid     = i_if_valid || i_ls_valid;
    assign o_owner     = (i_ls_valid && !w_if_forced) ? OWN_LS : OWN_IF;

endmodule

// File: rtl/ysyx_22041207_mem_arbiter.sv
// rtl/ysyx_22041207_mem_arbiter.sv - IF/LS single-port memory arbiter, one transaction in flight
// Optional perf counters are built when YSYX_22041207_ARB_PERF_EN is defined.
module ysyx_22041207_mem_arbiter
    import ysyx_22041207_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MAX_IF_WAIT = ARB_MAX_IF_WAIT,
    parameter int CNT_W       = ARB_CNT_W
)
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req_valid,
    output logic                o_if_req_ready,
    input  logic [ADDR_W-1:0]   i_if_req_addr,
    input  logic                i_if_flush,
    output logic                o_if_resp_valid,
    output logic [DATA_W-1:0]   o_if_resp_data,
    input  logic                i_ls_req_valid,
    output logic                o_ls_req_ready,
    input  logic [ADDR_W-1:0]   i_ls_req_addr,
    input  logic                i_ls_req_wen,
    input  logic [DATA_W-1:0]   i_ls_req_wdata,
    input  logic [DATA_W/8-1:0] i_ls_req_wmask,
    output logic                o_ls_resp_valid,
    output logic [DATA_W-1:0]   o_ls_resp_data,
`ifdef YSYX_22041207_ARB_PERF_EN
    output logic [31:0]         o_perf_if_grants,
    output logic [31:0]         o_perf_ls_grants,
    output logic [31:0]         o_perf_if_stall,
`endif
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_req_addr,
    output logic                o_mem_req_wen,
    output logic [DATA_W-1:0]   o_mem_req_wdata,
    output logic [DATA_W/8-1:0] o_mem_req_wmask,
    input  logic                i_mem_resp_valid,
    input  logic [DATA_W-1:0]   i_mem_resp_data
);

    arb_state_t       r_state, w_state_nxt;
    logic             r_owner, w_owner_nxt;
    logic             r_drop, w_drop_nxt;
    logic [CNT_W-1:0] r_starve_cnt, w_cnt_nxt;

    logic w_pick_valid, w_pick_owner;
    logic w_req_valid, w_req_owner;
    logic w_hs, w_if_hs, w_ls_hs, w_resp;

    ysyx_22041207_arb_pick #(
        .MAX_IF_WAIT (MAX_IF_WAIT),
        .CNT_W       (CNT_W)
    ) u_pick (
        .i_if_valid   (i_if_req_valid),
        .i_ls_valid   (i_ls_req_valid),
        .i_starve_cnt (r_starve_cnt),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick_owner)
    );

    // Fresh pick only in IDLE; LOCKED keeps the latched owner regardless of priority
    always_comb begin
        w_req_valid = 1'b0;
        w_req_owner = r_owner;
        case (r_state)
            ARB_IDLE: begin
                w_req_valid = w_pick_valid;
                w_req_owner = w_pick_owner;
            end
            ARB_LOCKED: w_req_valid = 1'b1;
            default:    w_req_valid = 1'b0;
        endcase
        if (i_rst) begin
            w_req_valid = 1'b0;
        end
    end

    assign w_hs    = w_req_valid && i_mem_req_ready;
    assign w_if_hs = w_hs && (w_req_owner == OWN_IF);
    assign w_ls_hs = w_hs && (w_req_owner == OWN_LS);
    assign w_resp  = (r_state == ARB_BUSY) && i_mem_resp_valid && !i_rst;

    assign o_mem_req_valid = w_req_valid;
    assign o_if_req_ready  = w_if_hs;
    assign o_ls_req_ready  = w_ls_hs;

    always_comb begin
        o_mem_req_addr  = '0;
        o_mem_req_wen   = 1'b0;
        o_mem_req_wdata = '0;
        o_mem_req_wmask = '0;
        if (w_req_valid) begin
            if (w_req_owner == OWN_LS) begin
                o_mem_req_addr  = i_ls_req_addr;
                o_mem_req_wen   = i_ls_req_wen;
                o_mem_req_wdata = i_ls_req_wdata;
                o_mem_req_wmask = i_ls_req_wmask;
            end else begin
                o_mem_req_addr  = i_if_req_addr;
            end
        end
    end

    // A flush landing on the response cycle kills it as well as a pending drop
    assign o_if_resp_valid = w_resp && (r_owner == OWN_IF) && !r_drop && !i_if_flush;
    assign o_ls_resp_valid = w_resp && (r_owner == OWN_LS);
    assign o_if_resp_data  = o_if_resp_valid ? i_mem_resp_data : '0;
    assign o_ls_resp_data  = o_ls_resp_valid ? i_mem_resp_data : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_drop_nxt  = r_drop;
        w_cnt_nxt   = r_starve_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_req_valid) begin
                    w_owner_nxt = w_req_owner;
                    w_state_nxt = i_mem_req_ready ? ARB_BUSY : ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (i_mem_req_ready) begin
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (i_mem_resp_valid) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase

        if (w_resp && (r_owner == OWN_IF)) begin
            w_drop_nxt = 1'b0;
        end else if (i_if_flush && (r_owner == OWN_IF) && (r_state != ARB_IDLE)) begin
            w_drop_nxt = 1'b1;
        end

        if (w_if_hs) begin
            w_cnt_nxt = '0;
        end else if (w_ls_hs && i_if_req_valid && (r_starve_cnt != CNT_W'(MAX_IF_WAIT))) begin
            w_cnt_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWN_IF;
            r_drop       <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_drop       <= w_drop_nxt;
            r_starve_cnt <= w_cnt_nxt;
        end
    end

`ifdef YSYX_22041207_ARB_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_if_grants <= '0;
            o_perf_ls_grants <= '0;
            o_perf_if_stall  <= '0;
        end else begin
            if (w_if_hs) begin
                o_perf_if_grants <= o_perf_if_grants + 32'd1;
            end
            if (w_ls_hs) begin
                o_perf_ls_grants <= o_perf_ls_grants + 32'd1;
            end
            if (i_if_req_valid && !o_if_req_ready) begin
                o_perf_if_stall <= o_perf_if_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// tb/tb_ysyx_22041207_mem_arbiter.sv - directed vector bench for the IF/LS memory arbiter
module tb_ysyx_22041207_mem_arbiter;

    localparam logic [63:0] WD = 64'hdead_beef_cafe_f00d;
    localparam logic [7:0]  WM = 8'h0f;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
    logic [63:0] if_req_addr, if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
    logic [7:0]  ls_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [7:0]  mem_req_wmask;
`ifdef YSYX_22041207_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_ls_grants, perf_if_stall;
`endif

    always #5 clk = ~clk;

    ysyx_22041207_mem_arbiter dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_if_req_valid   (if_req_valid),
        .o_if_req_ready   (if_req_ready),
        .i_if_req_addr    (if_req_addr),
        .i_if_flush       (if_flush),
        .o_if_resp_valid  (if_resp_valid),
        .o_if_resp_data   (if_resp_data),
        .i_ls_req_valid   (ls_req_valid),
        .o_ls_req_ready   (ls_req_ready),
        .i_ls_req_addr    (ls_req_addr),
        .i_ls_req_wen     (ls_req_wen),
        .i_ls_req_wdata   (ls_req_wdata),
        .i_ls_req_wmask   (ls_req_wmask),
        .o_ls_resp_valid  (ls_resp_valid),
        .o_ls_resp_data   (ls_resp_data),
`ifdef YSYX_22041207_ARB_PERF_EN
        .o_perf_if_grants (perf_if_grants),
        .o_perf_ls_grants (perf_ls_grants),
        .o_perf_if_stall  (perf_if_stall),
`endif
        .o_mem_req_valid  (mem_req_valid),
        .i_mem_req_ready  (mem_req_ready),
        .o_mem_req_addr   (mem_req_addr),
        .o_mem_req_wen    (mem_req_wen),
        .o_mem_req_wdata  (mem_req_wdata),
        .o_mem_req_wmask  (mem_req_wmask),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_resp_data  (mem_resp_data)
    );

    // sel: 0 = no request to memory, 1 = IF granted, 2 = LS granted
    typedef struct {
        string       name;
        logic        rst;
        logic        ifv;
        logic [63:0] ifa;
        logic        fl;
        logic        lsv;
        logic [63:0] lsa;
        logic        wen;
        logic        mrdy;
        logic        mrv;
        logic [63:0] mrd;
        int          sel;
        logic        e_ifrv;
        logic        e_lsrv;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input string name, input logic r, input logic ifv,
                                input logic [63:0] ifa, input logic fl, input logic lsv,
                                input logic [63:0] lsa, input logic wen, input logic mrdy,
                                input logic mrv, input logic [63:0] mrd, input int sel,
                                input logic e_ifrv, input logic e_lsrv);
        vec_t v;
        v.name = name; v.rst = r; v.ifv = ifv; v.ifa = ifa; v.fl = fl;
        v.lsv = lsv; v.lsa = lsa; v.wen = wen; v.mrdy = mrdy; v.mrv = mrv;
        v.mrd = mrd; v.sel = sel; v.e_ifrv = e_ifrv; v.e_lsrv = e_lsrv;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [269:0] got, exp;
        logic         e_ifr, e_lsr, e_mv, e_wen;
        logic [63:0]  e_ma, e_wd;
        logic [7:0]   e_wm;
        @(posedge clk);
        #1;
        rst            = v.rst;
        if_req_valid   = v.ifv;
        if_req_addr    = v.ifa;
        if_flush       = v.fl;
        ls_req_valid   = v.lsv;
        ls_req_addr    = v.lsa;
        ls_req_wen     = v.wen;
        mem_req_ready  = v.mrdy;
        mem_resp_valid = v.mrv;
        mem_resp_data  = v.mrd;
        @(negedge clk);
        e_mv  = (v.sel != 0);
        e_ifr = (v.sel == 1) && v.mrdy;
        e_lsr = (v.sel == 2) && v.mrdy;
        e_ma  = (v.sel == 1) ? v.ifa : ((v.sel == 2) ? v.lsa : 64'h0);
        e_wen = (v.sel == 2) && v.wen;
        e_wd  = (v.sel == 2) ? WD : 64'h0;
        e_wm  = (v.sel == 2) ? WM : 8'h0;
        exp = {e_ifr, e_lsr, e_mv, e_ma, e_wen, e_wd, e_wm,
               v.e_ifrv, (v.e_ifrv ? v.mrd : 64'h0), v.e_lsrv, (v.e_lsrv ? v.mrd : 64'h0)};
        got = {if_req_ready, ls_req_ready, mem_req_valid, mem_req_addr, mem_req_wen,
               mem_req_wdata, mem_req_wmask, if_resp_valid, if_resp_data,
               ls_resp_valid, ls_resp_data};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", v.name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
        ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0;
        ls_req_wdata = WD; ls_req_wmask = WM;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        //                 name            rst ifv ifa           fl lsv lsa           wen rdy rv rdata                sel ifrv lsrv
        tbl.push_back(mk("reset_outputs",  1, 1, 64'h8000_0000, 0, 1, 64'h8000_1000, 1, 1, 0, 64'h0,                0, 0, 0));
        tbl.push_back(mk("idle_empty",     0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 0, 64'h0,                0, 0, 0));
        tbl.push_back(mk("if_grant0",      0, 1, 64'h8000_0000, 0, 0, 64'h0,         0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("if_busy_wait",   0, 1, 64'h8000_0004, 0, 0, 64'h0,         0, 1, 0, 64'h0,                0, 0, 0));
        tbl.push_back(mk("if_resp0",       0, 1, 64'h8000_0004, 0, 0, 64'h0,         0, 1, 1, 64'h13,               0, 1, 0));
        tbl.push_back(mk("if_grant1",      0, 1, 64'h8000_0004, 0, 0, 64'h0,         0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("if_resp1_min2",  0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 1, 64'h0010_0093,        0, 1, 0));
        tbl.push_back(mk("both_ls_first",  0, 1, 64'h8000_0008, 0, 1, 64'h8000_1000, 1, 1, 0, 64'h0,                2, 0, 0));
        tbl.push_back(mk("ls_write_ack",   0, 1, 64'h8000_0008, 0, 0, 64'h0,         0, 0, 1, 64'h55,               0, 0, 1));
        tbl.push_back(mk("if_after_ls",    0, 1, 64'h8000_0008, 0, 0, 64'h0,         0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("if_resp2",       0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 1, 64'h0000_0017,        0, 1, 0));
        tbl.push_back(mk("lock_enter",     0, 1, 64'h8000_0010, 0, 0, 64'h0,         0, 0, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("lock_hold_ls1",  0, 1, 64'h8000_0010, 0, 1, 64'h8000_1008, 0, 0, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("lock_hold_ls2",  0, 1, 64'h8000_0010, 0, 1, 64'h8000_1008, 0, 0, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("lock_release",   0, 1, 64'h8000_0010, 0, 1, 64'h8000_1008, 0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("busy_flush",     0, 0, 64'h0,         1, 1, 64'h8000_1008, 0, 0, 0, 64'h0,                0, 0, 0));
        tbl.push_back(mk("flushed_resp",   0, 0, 64'h0,         0, 1, 64'h8000_1008, 0, 0, 1, 64'hbad,              0, 0, 0));
        tbl.push_back(mk("ls_read",        0, 0, 64'h0,         0, 1, 64'h8000_1008, 0, 1, 0, 64'h0,                2, 0, 0));
        tbl.push_back(mk("ls_resp_flush",  0, 0, 64'h0,         1, 0, 64'h0,         0, 0, 1, 64'h1234,             0, 0, 1));
        tbl.push_back(mk("if_after_flush", 0, 1, 64'h8000_0100, 0, 0, 64'h0,         0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("if_resp_normal", 0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 1, 64'h0000_0073,        0, 1, 0));
        tbl.push_back(mk("if_grant_104",   0, 1, 64'h8000_0104, 0, 0, 64'h0,         0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("flush_on_resp",  0, 0, 64'h0,         1, 0, 64'h0,         0, 0, 1, 64'h99,               0, 0, 0));
        tbl.push_back(mk("flush_idle",     0, 0, 64'h0,         1, 0, 64'h0,         0, 0, 0, 64'h0,                0, 0, 0));
        tbl.push_back(mk("if_grant_108",   0, 1, 64'h8000_0108, 0, 0, 64'h0,         0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("if_resp_108",    0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 1, 64'h42,               0, 1, 0));
        tbl.push_back(mk("stray_idle",     0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 1, 64'h77,               0, 0, 0));
        tbl.push_back(mk("ls_grant_pre",   0, 0, 64'h0,         0, 1, 64'h8000_1010, 1, 1, 0, 64'h0,                2, 0, 0));
        tbl.push_back(mk("rst_in_busy",    1, 0, 64'h0,         0, 0, 64'h0,         0, 0, 0, 64'h0,                0, 0, 0));
        tbl.push_back(mk("stray_post_rst", 0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 1, 64'h66,               0, 0, 0));
        tbl.push_back(mk("if_post_rst",    0, 1, 64'h8000_0200, 0, 0, 64'h0,         0, 1, 0, 64'h0,                1, 0, 0));
        tbl.push_back(mk("if_resp_post",   0, 0, 64'h0,         0, 0, 64'h0,         0, 0, 1, 64'h88,               0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // IF waits through four LS grants, takes the fifth, then LS wins again
        for (int k = 0; k < 6; k++) begin
            apply(mk($sformatf("starve_grant%0d", k), 0, 1, 64'h8000_0300, 0, 1, 64'h8000_1020, 1, 1, 0,
                     64'h0, (k == 4) ? 1 : 2, 0, 0));
            apply(mk($sformatf("starve_resp%0d", k), 0, 1, 64'h8000_0300, 0, 1, 64'h8000_1020, 1, 0, 1,
                     64'(k + 100), 0, (k == 4), (k != 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
